instr_loader: RTL and testbench

- Upstream feeder for the accumulator CPU core.
- Receives 9-bit instruction words over a 1-wire serial frame from the chip input pins, sampled on a strobe.
- Checks parity and framing, then buffers good words in a small FIFO.
- Issues each buffered word to the core's INSTRUCTION / write_en inputs as a registered one-cycle strobe, with programmable pacing and a hold input.

---
 rtl/instr_loader_if.sv | 27 ++
 rtl/instr_loader.sv | 155 +++++++++++++++
 tb/tb_instr_loader.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/instr_loader_if.sv
// Bus between the serial instruction feeder and its neighbours: serial input side,
// issue side towards the core, and status flags.
interface instr_loader_if #(
    parameter int unsigned WIDTH = 9
);
    logic             SDI;
    logic             SAMPLE_EN;
    logic             HOLD;
    logic             CLR_ERR;
    logic [WIDTH-1:0] INSTRUCTION;
    logic             write_en;
    logic             EMPTY;
    logic             FULL;
    logic             PARITY_ERR;
    logic             FRAME_ERR;
    logic             OVERFLOW;

    modport master (
        output SDI, SAMPLE_EN, HOLD, CLR_ERR,
        input  INSTRUCTION, write_en, EMPTY, FULL, PARITY_ERR, FRAME_ERR, OVERFLOW
    );

    modport slave (
        input  SDI, SAMPLE_EN, HOLD, CLR_ERR,
        output INSTRUCTION, write_en, EMPTY, FULL, PARITY_ERR, FRAME_ERR, OVERFLOW
    );
endinterface

// File: rtl/instr_loader.sv
// Serial instruction receiver with parity/framing checks, a small FIFO and a paced,
// registered issue strobe towards the accumulator core.
module instr_loader #(
    parameter int unsigned WIDTH     = 9,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned ISSUE_GAP = 0
) (
    input  logic          CLK,
    input  logic          RESET_N,
    instr_loader_if.slave bus
);
    localparam int unsigned IW = $clog2(WIDTH);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned GW = (ISSUE_GAP > 0) ? $clog2(ISSUE_GAP + 1) : 1;

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} rx_state_e;

    rx_state_e        r_state;
    logic [IW-1:0]    r_idx;
    logic [WIDTH-1:0] r_shift;
    logic             r_par;
    logic             r_perr;
    logic             r_ferr;
    logic             r_ovf;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [PW:0]      r_count;
    logic [GW-1:0]    r_gap;
    logic [WIDTH-1:0] r_instr;
    logic             r_we;

    logic w_stop;
    logic w_par_ok;
    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;
    logic w_set_perr;
    logic w_set_ferr;
    logic w_set_ovf;

    assign w_stop     = bus.SAMPLE_EN && (r_state == StStop);
    assign w_par_ok   = ~^{r_shift, r_par};
    assign w_full     = (r_count == (PW+1)'(DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_pop      = !w_empty && !bus.HOLD && (r_gap == '0);
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign w_push     = w_stop && bus.SDI && w_par_ok && (!w_full || w_pop);
    assign w_set_ferr = w_stop && !bus.SDI;
    assign w_set_perr = w_stop && bus.SDI && !w_par_ok;
    assign w_set_ovf  = w_stop && bus.SDI && w_par_ok && w_full && !w_pop;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= StIdle;
            r_idx   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (bus.SAMPLE_EN) begin
                unique case (r_state)
                    StIdle: begin
                        if (!bus.SDI) begin
                            r_state <= StData;
                            r_idx   <= '0;
                        end
                    end
                    StData: begin
                        r_shift[r_idx] <= bus.SDI;
                        if (r_idx == IW'(WIDTH - 1)) begin
                            r_state <= StParity;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                    StParity: begin
                        r_par   <= bus.SDI;
                        r_state <= StStop;
                    end
                    StStop: begin
                        r_state <= StIdle;
                    end
                    default: r_state <= StIdle;
                endcase
            end

            // Sticky flags: a new error in the clearing cycle survives the clear.
            if (w_set_perr) begin
                r_perr <= 1'b1;
            end else if (bus.CLR_ERR) begin
                r_perr <= 1'b0;
            end
            if (w_set_ferr) begin
                r_ferr <= 1'b1;
            end else if (bus.CLR_ERR) begin
                r_ferr <= 1'b0;
            end
            if (w_set_ovf) begin
                r_ovf <= 1'b1;
            end else if (bus.CLR_ERR) begin
                r_ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_gap   <= '0;
            r_instr <= '0;
            r_we    <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= r_shift;
                r_wptr        <= r_wptr + 1'b1;
            end

            if (w_pop) begin
                r_instr <= r_mem[r_rptr];
                r_rptr  <= r_rptr + 1'b1;
                r_gap   <= GW'(ISSUE_GAP);
                r_we    <= 1'b1;
            end else begin
                r_we <= 1'b0;
                if (r_gap != '0) begin
                    r_gap <= r_gap - 1'b1;
                end
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.INSTRUCTION = r_instr;
    assign bus.write_en    = r_we;
    assign bus.EMPTY       = w_empty;
    assign bus.FULL        = w_full;
    assign bus.PARITY_ERR  = r_perr;
    assign bus.FRAME_ERR   = r_ferr;
    assign bus.OVERFLOW    = r_ovf;
endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: one instance back-to-back, one with an issue gap of 2,
// both fed from the same serial stimulus.
module tb_instr_loader;
    logic CLK;
    logic RESET_N;
    int   checks;
    int   errors;
    int   n_we;
    int   n0;

    instr_loader_if #(.WIDTH(9)) u_if ();
    instr_loader_if #(.WIDTH(9)) u_if2 ();

    assign u_if2.SDI       = u_if.SDI;
    assign u_if2.SAMPLE_EN = u_if.SAMPLE_EN;
    assign u_if2.HOLD      = u_if.HOLD;
    assign u_if2.CLR_ERR   = u_if.CLR_ERR;

    instr_loader #(.WIDTH(9), .DEPTH(4), .ISSUE_GAP(0)) u_dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (u_if.slave)
    );

    instr_loader #(.WIDTH(9), .DEPTH(4), .ISSUE_GAP(2)) u_dut_gap (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (u_if2.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (u_if.write_en === 1'b1) n_we <= n_we + 1;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One slot every 4th cycle: start, d0..d8, parity, stop.
    task automatic send_frame(input logic [8:0] w, input logic p, input logic stp,
                              input bit exp_issue, input bit clr_at_stop);
        logic [11:0] bits;
        bits = {stp, p, w, 1'b0};
        for (int i = 0; i < 12; i++) begin
            u_if.SDI       = bits[i];
            u_if.SAMPLE_EN = 1'b1;
            if (i == 11 && clr_at_stop) u_if.CLR_ERR = 1'b1;
            tick();
            u_if.SAMPLE_EN = 1'b0;
            u_if.CLR_ERR   = 1'b0;
            u_if.SDI       = 1'b1;
            if (i == 11 && exp_issue) begin
                check("lat_we_low", u_if.write_en, 1'b0);
                tick();
                check("lat_we_high", u_if.write_en, 1'b1);
                check("lat_instr", u_if.INSTRUCTION, w);
                tick();
                check("lat_we_drop", u_if.write_en, 1'b0);
                tick();
            end else begin
                tick();
                tick();
                tick();
            end
        end
    endtask

    task automatic good_frame(input logic [8:0] w, input bit exp_issue);
        send_frame(w, ^w, 1'b1, exp_issue, 1'b0);
    endtask

    task automatic clear_flags();
        u_if.CLR_ERR = 1'b1;
        tick();
        u_if.CLR_ERR = 1'b0;
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        n_we           = 0;
        RESET_N        = 1'b0;
        u_if.SDI       = 1'b1;
        u_if.SAMPLE_EN = 1'b0;
        u_if.HOLD      = 1'b0;
        u_if.CLR_ERR   = 1'b0;
        tick();
        tick();
        check("rst_instr", u_if.INSTRUCTION, 9'h000);
        check("rst_we", u_if.write_en, 1'b0);
        check("rst_empty", u_if.EMPTY, 1'b1);
        check("rst_full", u_if.FULL, 1'b0);
        check("rst_flags", {u_if.PARITY_ERR, u_if.FRAME_ERR, u_if.OVERFLOW}, 3'b000);
        RESET_N = 1'b1;
        tick();

        // Single good frame
        n0 = n_we;
        send_frame(9'h0A3, 1'b0, 1'b1, 1'b1, 1'b0);
        check("single_pulses", n_we, n0 + 1);
        check("single_flags", {u_if.PARITY_ERR, u_if.FRAME_ERR, u_if.OVERFLOW}, 3'b000);
        check("single_empty", u_if.EMPTY, 1'b1);

        // Bad parity, then clear, then set-vs-clear collision
        n0 = n_we;
        send_frame(9'h1FF, 1'b0, 1'b1, 1'b0, 1'b0);
        check("par_err", u_if.PARITY_ERR, 1'b1);
        check("par_empty", u_if.EMPTY, 1'b1);
        check("par_no_we", n_we, n0);
        clear_flags();
        check("par_clr", u_if.PARITY_ERR, 1'b0);
        send_frame(9'h1FF, 1'b0, 1'b1, 1'b0, 1'b1);
        check("par_set_wins", u_if.PARITY_ERR, 1'b1);
        clear_flags();
        check("par_clr2", u_if.PARITY_ERR, 1'b0);

        // Bad stop bit, then a good frame
        n0 = n_we;
        send_frame(9'h0A3, 1'b0, 1'b0, 1'b0, 1'b0);
        check("frm_err", u_if.FRAME_ERR, 1'b1);
        check("frm_no_par", u_if.PARITY_ERR, 1'b0);
        check("frm_no_we", n_we, n0);
        good_frame(9'h005, 1'b1);
        check("frm_next_pulses", n_we, n0 + 1);
        clear_flags();
        check("frm_clr", u_if.FRAME_ERR, 1'b0);

        // Fill under HOLD, overflow, then drain back-to-back
        u_if.HOLD = 1'b1;
        for (int i = 1; i <= 4; i++) good_frame(9'(i), 1'b0);
        check("hold_full", u_if.FULL, 1'b1);
        check("hold_no_ovf", u_if.OVERFLOW, 1'b0);
        good_frame(9'h005, 1'b0);
        check("hold_ovf", u_if.OVERFLOW, 1'b1);
        check("hold_still_full", u_if.FULL, 1'b1);
        u_if.HOLD = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("drain_we", u_if.write_en, 1'b1);
            check("drain_instr", u_if.INSTRUCTION, 9'(i));
        end
        tick();
        check("drain_we_end", u_if.write_en, 1'b0);
        check("drain_empty", u_if.EMPTY, 1'b1);
        clear_flags();
        check("ovf_clr", u_if.OVERFLOW, 1'b0);
        for (int i = 0; i < 20; i++) tick();

        // Issue gap of 2 on the second instance
        u_if.HOLD = 1'b1;
        good_frame(9'h011, 1'b0);
        good_frame(9'h022, 1'b0);
        good_frame(9'h033, 1'b0);
        u_if.HOLD = 1'b0;
        tick();
        check("gap_k_we", u_if2.write_en, 1'b1);
        check("gap_k_instr", u_if2.INSTRUCTION, 9'h011);
        tick();
        check("gap_k1_we", u_if2.write_en, 1'b0);
        check("gap_k1_hold", u_if2.INSTRUCTION, 9'h011);
        tick();
        check("gap_k2_we", u_if2.write_en, 1'b0);
        tick();
        check("gap_k3_we", u_if2.write_en, 1'b1);
        check("gap_k3_instr", u_if2.INSTRUCTION, 9'h022);
        tick();
        check("gap_k4_we", u_if2.write_en, 1'b0);
        tick();
        check("gap_k5_we", u_if2.write_en, 1'b0);
        check("gap_k5_hold", u_if2.INSTRUCTION, 9'h022);
        tick();
        check("gap_k6_we", u_if2.write_en, 1'b1);
        check("gap_k6_instr", u_if2.INSTRUCTION, 9'h033);
        for (int i = 0; i < 10; i++) tick();

        // Reset in the middle of a frame with a queued word and a sticky flag
        u_if.HOLD = 1'b1;
        good_frame(9'h055, 1'b0);
        check("pre_rst_not_empty", u_if.EMPTY, 1'b0);
        send_frame(9'h1FF, 1'b0, 1'b1, 1'b0, 1'b0);
        check("pre_rst_perr", u_if.PARITY_ERR, 1'b1);
        begin
            logic [11:0] bits;
            logic [8:0]  w;
            w    = 9'h12C;
            bits = {1'b1, ^w, w, 1'b0};
            for (int i = 0; i < 6; i++) begin
                u_if.SDI       = bits[i];
                u_if.SAMPLE_EN = 1'b1;
                tick();
                u_if.SAMPLE_EN = 1'b0;
                u_if.SDI       = 1'b1;
                tick();
            end
        end
        RESET_N = 1'b0;
        #1;
        check("mid_rst_instr", u_if.INSTRUCTION, 9'h000);
        check("mid_rst_we", u_if.write_en, 1'b0);
        check("mid_rst_empty", u_if.EMPTY, 1'b1);
        check("mid_rst_full", u_if.FULL, 1'b0);
        check("mid_rst_flags", {u_if.PARITY_ERR, u_if.FRAME_ERR, u_if.OVERFLOW}, 3'b000);
        tick();
        tick();
        RESET_N   = 1'b1;
        u_if.HOLD = 1'b0;
        tick();
        n0 = n_we;
        good_frame(9'h12C, 1'b1);
        check("post_rst_pulses", n_we, n0 + 1);
        check("post_rst_flags", {u_if.PARITY_ERR, u_if.FRAME_ERR, u_if.OVERFLOW}, 3'b000);
        check("post_rst_empty", u_if.EMPTY, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
